// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared predictor types and constants                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DS  = 2'd1,
        REDIRECT = 2'd2
    } bp_state_e;

    // Fall-through PC of a not-taken branch skips the branch and its delay slot.
    localparam logic [31:0] DELAY_SLOT_BYTES = 32'd8;

endpackage
`default_nettype wire

// File: rtl/id_branch_predictor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_branch_predictor_if : IF lookup, ID resolve and redirect bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface id_branch_predictor_if #(
    parameter int PERF_W = 32
) ();
    logic [31:0]       if_pc;
    logic              if_valid;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic              id_is_cond;
    logic              id_is_jump;
    logic              id_taken;
    logic [31:0]       id_target;
    logic              id_pred_taken;
    logic [31:0]       id_pred_tgt;
    logic              flush;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              busy;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispred;

    modport master (
        output if_pc, if_valid, id_valid, id_pc, id_is_cond, id_is_jump,
               id_taken, id_target, id_pred_taken, id_pred_tgt, flush,
        input  pred_taken, pred_target, redirect, redirect_pc, busy,
               perf_branches, perf_mispred
    );

    modport slave (
        input  if_pc, if_valid, id_valid, id_pc, id_is_cond, id_is_jump,
               id_taken, id_target, id_pred_taken, id_pred_tgt, flush,
        output pred_taken, pred_target, redirect, redirect_pc, busy,
               perf_branches, perf_mispred
    );
endinterface
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bp_sat_counter : per-entry saturating direction counter              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bp_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic inc,
    input  logic dec,
    output logic predict_taken
);
    localparam logic [CNT_W-1:0] c_weak_taken     = (CNT_W)'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] c_weak_not_taken = c_weak_taken - (CNT_W)'(1);
    localparam logic [CNT_W-1:0] c_max            = '1;

    logic [CNT_W-1:0] r_cnt;

    // load marks a fresh allocation and wins over inc/dec.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= c_weak_not_taken;
        end else if (load) begin
            r_cnt <= c_weak_taken;
        end else if (inc) begin
            if (r_cnt != c_max) r_cnt <= r_cnt + (CNT_W)'(1);
        end else if (dec) begin
            if (r_cnt != '0) r_cnt <= r_cnt - (CNT_W)'(1);
        end
    end

    assign predict_taken = r_cnt[CNT_W-1];

endmodule
`default_nettype wire

// File: rtl/id_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_branch_predictor : direct-mapped BTB with delay-slot recovery FSM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                clk,
    input  logic                resetn,
    id_branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0]  w_if_idx, w_id_idx;
    logic [TAG_W-1:0]  w_if_tag, w_id_tag;
    logic              w_if_hit, w_id_hit;
    logic              w_resolve, w_mispred, w_wr_taken, w_wr_dec;
    logic [31:0]       w_rec_pc;
    logic              w_unused_pc;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_jump;
    logic [ENTRIES-1:0] w_cnt_taken;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];

    bp_state_e         r_state, w_state_nxt;
    logic              w_redirect;
    logic [31:0]       r_redirect_pc;
    logic [PERF_W-1:0] r_perf_br, r_perf_mp;

    assign w_if_idx    = bp.if_pc[2 +: IDX_W];
    assign w_if_tag    = bp.if_pc[2 + IDX_W +: TAG_W];
    assign w_id_idx    = bp.id_pc[2 +: IDX_W];
    assign w_id_tag    = bp.id_pc[2 + IDX_W +: TAG_W];
    assign w_unused_pc = ^bp.if_pc;

    assign w_if_hit        = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bp.pred_taken   = w_if_hit && (r_jump[w_if_idx] || w_cnt_taken[w_if_idx]);
    assign bp.pred_target  = w_if_hit ? r_target[w_if_idx] : 32'd0;

    assign w_resolve = bp.id_valid && (bp.id_is_cond || bp.id_is_jump)
                     && (r_state == IDLE) && !bp.flush;
    assign w_mispred = (bp.id_taken != bp.id_pred_taken)
                     || (bp.id_taken && (bp.id_target != bp.id_pred_tgt));
    assign w_rec_pc  = bp.id_taken ? bp.id_target : bp.id_pc + DELAY_SLOT_BYTES;

    assign w_id_hit   = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
    assign w_wr_taken = w_resolve && bp.id_taken;
    assign w_wr_dec   = w_resolve && !bp.id_taken && w_id_hit
                      && !bp.id_is_jump && !r_jump[w_id_idx];

    generate
        for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
            logic w_sel;
            assign w_sel = (w_id_idx == IDX_W'(i));
            bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk           (clk),
                .resetn        (resetn),
                .load          (w_sel && w_wr_taken && !w_id_hit),
                .inc           (w_sel && w_wr_taken && w_id_hit),
                .dec           (w_sel && w_wr_dec),
                .predict_taken (w_cnt_taken[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (w_wr_taken) begin
            r_valid[w_id_idx] <= 1'b1;
        end
    end

    // Payload is only meaningful behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr_taken) begin
            r_tag[w_id_idx]    <= w_id_tag;
            r_target[w_id_idx] <= bp.id_target;
            r_jump[w_id_idx]   <= bp.id_is_jump;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_redirect  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_resolve && w_mispred) begin
                    w_state_nxt = bp.if_valid ? REDIRECT : WAIT_DS;
                end
            end
            WAIT_DS: begin
                if (bp.if_valid) w_state_nxt = REDIRECT;
            end
            REDIRECT: begin
                w_redirect  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (bp.flush) begin
            w_state_nxt = IDLE;
            w_redirect  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_pc <= 32'd0;
            r_perf_br     <= '0;
            r_perf_mp     <= '0;
        end else if (w_resolve) begin
            r_redirect_pc <= w_rec_pc;
            if (r_perf_br != '1) r_perf_br <= r_perf_br + PERF_W'(1);
            if (w_mispred && (r_perf_mp != '1)) r_perf_mp <= r_perf_mp + PERF_W'(1);
        end
    end

    assign bp.redirect      = w_redirect;
    assign bp.redirect_pc   = r_redirect_pc;
    assign bp.busy          = (r_state != IDLE);
    assign bp.perf_branches = r_perf_br;
    assign bp.perf_mispred  = r_perf_mp;

endmodule
`default_nettype wire
